// File: rtl/major_state_pkg.sv
// Purpose: shared state codes, opcode constants and instruction decode for the PDP-8/e major-state sequencer.
// Latency: none. The decode is pure combinational logic.
// Backpressure: none.
package major_state_pkg;

  // Minor/major state codes shared with the PC, MA, AC and memory blocks.
  typedef enum logic [3:0] {
    ST_F0 = 4'd0,  ST_F1 = 4'd1,  ST_F2 = 4'd2,  ST_F3 = 4'd3,
    ST_D0 = 4'd4,  ST_D1 = 4'd5,  ST_D2 = 4'd6,  ST_D3 = 4'd7,
    ST_E0 = 4'd8,  ST_E1 = 4'd9,  ST_E2 = 4'd10, ST_E3 = 4'd11,
    ST_H0 = 4'd12, ST_H1 = 4'd13, ST_H2 = 4'd14, ST_H3 = 4'd15
  } state_e;

  // Opcode field instruction[0:2].
  localparam logic [2:0] OP_AND = 3'o0;
  localparam logic [2:0] OP_TAD = 3'o1;
  localparam logic [2:0] OP_ISZ = 3'o2;
  localparam logic [2:0] OP_DCA = 3'o3;
  localparam logic [2:0] OP_JMS = 3'o4;
  localparam logic [2:0] OP_JMP = 3'o5;
  localparam logic [2:0] OP_IOT = 3'o6;
  localparam logic [2:0] OP_OPR = 3'o7;

  // JMP with the indirect bit, instruction[0:3].
  localparam logic [3:0] OP_JMPD = 4'b1010;
  localparam logic [3:0] OP_JMPI = 4'b1011;

  typedef struct packed {
    logic mri;      // memory-reference instruction (AND..JMP)
    logic ind;      // indirect bit
    logic jmp_dir;  // JMP direct: done at F3
    logic jmp_ind;  // JMP indirect: done at D3
    logic hlt;      // group-2 OPR with HLT bit set
  } ir_dec_t;

  function automatic ir_dec_t decode_ir(input logic [0:11] ir);
    ir_dec_t d;
    d     = '0;
    d.ind = ir[3];
    case (ir[0:2])
      OP_AND, OP_TAD, OP_ISZ, OP_DCA, OP_JMS, OP_JMP: d.mri = 1'b1;
      OP_IOT, OP_OPR:                                 d.mri = 1'b0;
    endcase
    d.jmp_dir = (ir[0:3] == OP_JMPD);
    d.jmp_ind = (ir[0:3] == OP_JMPI);
    d.hlt     = (ir[0:2] == OP_OPR) && ir[3] && ir[10] && !ir[11];
    return d;
  endfunction

endpackage

// File: rtl/major_state_if.sv
// Purpose: bundles the panel/instruction inputs and the state outputs of the major-state sequencer.
// Latency: none. These are wires only.
// Backpressure: none. The inputs are level signals, and the outputs are valid every cycle.
// Ports: master drives instruction, halt_sw, sing_step, cont and int_req.
//        slave (the sequencer) drives state, run, int_in_prog and instr_done.
interface major_state_if;
  logic [0:11] instruction;
  logic        halt_sw;
  logic        sing_step;
  logic        cont;
  logic        int_req;
  logic [3:0]  state;
  logic        run;
  logic        int_in_prog;
  logic        instr_done;

  modport master (
    output instruction, halt_sw, sing_step, cont, int_req,
    input  state, run, int_in_prog, instr_done
  );

  modport slave (
    input  instruction, halt_sw, sing_step, cont, int_req,
    output state, run, int_in_prog, instr_done
  );
endinterface

// File: rtl/major_state_edge_det.sv
// Purpose: registered rising-edge detector for a front-panel level switch.
// Latency: rise is combinational from sig against last cycle's sampled copy.
// Backpressure: none.
// Ports: clk, reset (async, active-high), sig (level in), rise (high while sig=1 and the previous sample was 0).
module edge_det #(
  parameter bit RESET_VAL = 1'b1  // 1 prevents a switch held through reset from looking like an edge
) (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise
);
  logic sig_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sig_q <= RESET_VAL;
    else       sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
endmodule

// File: rtl/major_state.sv
// Purpose: PDP-8/e timing/major-state sequencer (F/D/E/H minor states, interrupt entry, halt and continue).
// Latency: state is registered. run, int_in_prog and instr_done are valid in the cycle of the current state.
// Backpressure: none. Panel switches are levels, and cont is edge-detected and only honoured while halted.
// Ports: clk, reset (async, active-high), bus (major_state_if.slave).
module major_state
  import major_state_pkg::*;
#(
  parameter bit START_RUN = 1'b0
) (
  input logic          clk,
  input logic          reset,
  major_state_if.slave bus
);
  state_e  state_q, state_d;
  logic    int_q, int_d;
  logic    halt_req_q, halt_req_d;
  logic    cont_pend_q, cont_pend_d;
  logic    cont_rise;
  logic    in_halt;
  logic    eoi;
  logic    hlt_seen;
  ir_dec_t dec;

  edge_det #(.RESET_VAL(1'b1)) u_cont_edge (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.cont),
    .rise  (cont_rise)
  );

  assign dec      = decode_ir(bus.instruction);
  assign in_halt  = state_q[3] & state_q[2];
  assign hlt_seen = (state_q == ST_F3) && dec.hlt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= START_RUN ? ST_F0 : ST_H0;
      int_q       <= 1'b0;
      halt_req_q  <= 1'b0;
      cont_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      int_q       <= int_d;
      halt_req_q  <= halt_req_d;
      cont_pend_q <= cont_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    int_d   = int_q;
    eoi     = 1'b0;

    case (state_q)
      ST_F3: begin
        if (dec.mri && dec.ind)           state_d = ST_D0;
        else if (dec.mri && !dec.jmp_dir) state_d = ST_E0;
        else                              eoi     = 1'b1;
      end
      ST_D3: begin
        if (dec.jmp_ind) eoi     = 1'b1;
        else             state_d = ST_E0;
      end
      ST_E3:   eoi     = 1'b1;
      ST_H3:   state_d = cont_pend_q ? ST_F0 : ST_H0;
      default: state_d = state_e'(state_q + 4'd1);
    endcase

    // An interrupt's own E3 is an end of instruction with int_q set, so it
    // can halt but cannot chain straight into a second interrupt.
    if (eoi) begin
      if (bus.halt_sw || bus.sing_step || halt_req_q || hlt_seen) begin
        state_d = ST_H0;
        int_d   = 1'b0;
      end else if (bus.int_req && !int_q) begin
        state_d = ST_E0;
        int_d   = 1'b1;
      end else begin
        state_d = ST_F0;
        int_d   = 1'b0;
      end
    end

    halt_req_d = (halt_req_q | hlt_seen) & (state_d != ST_H0);

    // Only edges seen while halted count, and the pending edge is consumed at H3.
    cont_pend_d = in_halt & ((cont_pend_q & (state_q != ST_H3)) | cont_rise);
  end

  assign bus.state       = state_q;
  assign bus.run         = ~state_q[3] | ~state_q[2];
  assign bus.int_in_prog = int_q;
  assign bus.instr_done  = eoi;
endmodule

// File: tb/tb_major_state.sv
// Purpose: self-checking bench for major_state (START_RUN=0) with a per-cycle expected-output scoreboard.
// Latency: expectations are compared 1 time unit after each rising clock edge.
// Backpressure: none.
module tb_major_state;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  // Expected word: {run, int_in_prog, instr_done, state}
  logic [6:0] sb[$];
  logic [6:0] exp_w;

  major_state_if bus ();

  major_state #(.START_RUN(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table entries are state + 16*instr_done + 32*int_in_prog, and run is implied by state < 12.
  function automatic logic [6:0] enc(input int v);
    logic [5:0] b;
    b = v[5:0];
    return {(b[3:0] < 4'd12), b};
  endfunction

  function automatic logic [6:0] obs();
    return {bus.run, bus.int_in_prog, bus.instr_done, bus.state};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    bus.instruction = 12'o7000;
    bus.halt_sw = 0; bus.sing_step = 0; bus.cont = 0; bus.int_req = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.state !== 4'd12) begin errors++; $display("FAIL reset_state got %0d exp 12", bus.state); end
    checks++; if (bus.run !== 1'b0) begin errors++; $display("FAIL reset_run got %b exp 0", bus.run); end
    checks++; if (bus.int_in_prog !== 1'b0) begin errors++; $display("FAIL reset_iip got %b exp 0", bus.int_in_prog); end
    checks++; if (bus.instr_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.instr_done); end
    reset = 1'b0;
  endtask

  task automatic test_halt_loop();
    int seq [8] = '{13, 14, 15, 12, 13, 14, 15, 12};
    foreach (seq[k]) sb.push_back(enc(seq[k]));
    for (int i = 0; i < $size(seq); i++) begin
      @(posedge clk); #1;
      exp_w = sb.pop_front();
      checks++;
      if (obs() !== exp_w) begin errors++; $display("FAIL halt_loop cyc %0d got %b exp %b", i, obs(), exp_w); end
    end
  endtask

  task automatic test_run_nop();
    int seq [12] = '{13, 14, 15, 0, 1, 2, 19, 0, 1, 2, 19, 0};
    foreach (seq[k]) sb.push_back(enc(seq[k]));
    for (int i = 0; i < $size(seq); i++) begin
      case (i)
        1: begin bus.cont = 1; bus.instruction = 12'o7000; end
        5: bus.cont = 0;
        default: ;
      endcase
      @(posedge clk); #1;
      exp_w = sb.pop_front();
      checks++;
      if (obs() !== exp_w) begin errors++; $display("FAIL run_nop cyc %0d got %b exp %b", i, obs(), exp_w); end
    end
  endtask

  task automatic test_indirect();
    int seq [20] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 27, 0,
                     1, 2, 3, 4, 5, 6, 23, 0};
    foreach (seq[k]) sb.push_back(enc(seq[k]));
    for (int i = 0; i < $size(seq); i++) begin
      case (i)
        0:  bus.instruction = 12'o1410;
        12: bus.instruction = 12'o5410;
        default: ;
      endcase
      @(posedge clk); #1;
      exp_w = sb.pop_front();
      checks++;
      if (obs() !== exp_w) begin errors++; $display("FAIL indirect cyc %0d got %b exp %b", i, obs(), exp_w); end
    end
  endtask

  task automatic test_hlt_cont();
    int seq [36] = '{1, 2, 19, 12,
                     13, 14, 15, 0, 1, 2, 19, 12, 13, 14, 15, 12, 13, 14, 15, 12,
                     13, 14, 15, 12, 13, 14, 15, 12,
                     13, 14, 15, 0, 1, 2, 19, 12};
    foreach (seq[k]) sb.push_back(enc(seq[k]));
    for (int i = 0; i < $size(seq); i++) begin
      case (i)
        0:  bus.instruction = 12'o7402;
        4:  bus.cont = 1;   // held high for 20 cycles
        24: bus.cont = 0;
        28: bus.cont = 1;   // fresh edge
        30: bus.cont = 0;
        default: ;
      endcase
      @(posedge clk); #1;
      exp_w = sb.pop_front();
      checks++;
      if (obs() !== exp_w) begin errors++; $display("FAIL hlt_cont cyc %0d got %b exp %b", i, obs(), exp_w); end
    end
  endtask

  task automatic test_interrupt();
    int seq [24] = '{13, 14, 15, 0, 1, 2, 3, 8, 9, 10, 27,
                     40, 41, 42, 59, 0,
                     1, 2, 3, 8, 9, 10, 27, 12};
    foreach (seq[k]) sb.push_back(enc(seq[k]));
    for (int i = 0; i < $size(seq); i++) begin
      case (i)
        0:  begin bus.instruction = 12'o3010; bus.int_req = 1; bus.cont = 1; end
        1:  bus.cont = 0;
        12: bus.int_req = 0;
        16: begin bus.int_req = 1; bus.halt_sw = 1; end
        default: ;
      endcase
      @(posedge clk); #1;
      exp_w = sb.pop_front();
      checks++;
      if (obs() !== exp_w) begin errors++; $display("FAIL interrupt cyc %0d got %b exp %b", i, obs(), exp_w); end
    end
    bus.int_req = 0;
    bus.halt_sw = 0;
  endtask

  task automatic test_single_step();
    int seq [24] = '{13, 14, 15, 0, 1, 2, 3, 8, 9, 10, 27, 12,
                     13, 14, 15, 0, 1, 2, 3, 8, 9, 10, 27, 12};
    foreach (seq[k]) sb.push_back(enc(seq[k]));
    for (int i = 0; i < $size(seq); i++) begin
      case (i)
        0:  begin bus.instruction = 12'o2020; bus.sing_step = 1; bus.cont = 1; end
        1:  bus.cont = 0;
        12: bus.cont = 1;
        13: bus.cont = 0;
        default: ;
      endcase
      @(posedge clk); #1;
      exp_w = sb.pop_front();
      checks++;
      if (obs() !== exp_w) begin errors++; $display("FAIL single_step cyc %0d got %b exp %b", i, obs(), exp_w); end
    end
  endtask

  task automatic test_async_reset();
    int seq [13] = '{13, 14, 15, 0, 1, 2, 3, 8, 9, 10, 27, 40, 41};
    foreach (seq[k]) sb.push_back(enc(seq[k]));
    for (int i = 0; i < $size(seq); i++) begin
      case (i)
        0: begin bus.sing_step = 0; bus.instruction = 12'o2020; bus.int_req = 1; bus.cont = 1; end
        1: bus.cont = 0;
        default: ;
      endcase
      @(posedge clk); #1;
      exp_w = sb.pop_front();
      checks++;
      if (obs() !== exp_w) begin errors++; $display("FAIL async_pre cyc %0d got %b exp %b", i, obs(), exp_w); end
    end
    // Interrupt E1 with int_in_prog=1. Reset between clock edges must act at once.
    reset = 1'b1;
    #1;
    checks++; if (bus.state !== 4'd12) begin errors++; $display("FAIL async_state got %0d exp 12", bus.state); end
    checks++; if (bus.int_in_prog !== 1'b0) begin errors++; $display("FAIL async_iip got %b exp 0", bus.int_in_prog); end
    checks++; if (bus.run !== 1'b0) begin errors++; $display("FAIL async_run got %b exp 0", bus.run); end
    bus.int_req = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.state !== 4'd13) begin errors++; $display("FAIL post_reset_state got %0d exp 13", bus.state); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d checks", checks);
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_halt_loop();
    test_run_nop();
    test_indirect();
    test_hlt_cont();
    test_interrupt();
    test_single_step();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
